mem_port_arbiter: RTL

- Shares one single-ported synchronous memory between the CPU instruction-fetch port and its load/store data port.
- Arbitrates requests, sequences each access through issue, wait and response phases, and returns read data or a write acknowledge to the winning requester.
- Sits between the multi-cycle CPU and a unified instruction/data memory.

---
 rtl/mem_arb_pkg.sv | 21 ++
 rtl/mem_arb_prio.sv | 34 +++
 rtl/mem_port_arbiter.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and constants for the memory port arbiter.
//   state_e    : access sequencer states (IDLE -> ISSUE -> WAIT -> RESP)
//   PORT_I/D   : owner encoding for the instruction and data ports
//   RD_LAT_MAX : largest supported memory read latency
//   CNT_W      : width of the wait-phase counter (holds RD_LAT_MAX-1)
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_e;

  localparam logic PORT_I = 1'b0;
  localparam logic PORT_D = 1'b1;

  localparam int RD_LAT_MAX = 7;
  localparam int CNT_W      = 3;

endpackage

// File: rtl/mem_arb_prio.sv
// mem_arb_prio: combinational winner select between the instruction and
// data ports.
//   i_req, d_req : pending requests
//   last_win     : previous winner (only with ARB_ROUND_ROBIN_EN)
//   any_req      : at least one request present
//   win          : winning port (PORT_I / PORT_D), meaningful with any_req
// Build option ARB_ROUND_ROBIN_EN: on simultaneous requests the port that
// did not win last time gets priority; otherwise the data port always wins.
module mem_arb_prio
  import mem_arb_pkg::*;
(
  input  logic i_req,
  input  logic d_req,
`ifdef ARB_ROUND_ROBIN_EN
  input  logic last_win,
`endif
  output logic any_req,
  output logic win
);

  always_comb begin
    any_req = i_req | d_req;
    win     = PORT_D;
    if (i_req && !d_req) begin
      win = PORT_I;
    end
`ifdef ARB_ROUND_ROBIN_EN
    else if (i_req && d_req) begin
      win = ~last_win;
    end
`endif
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported synchronous memory between the
// CPU instruction-fetch port and the load/store data port. Each access runs
// IDLE (grant + capture) -> ISSUE (mem_en) -> WAIT (RD_LAT cycles) -> RESP
// (rvalid to the owner).
//   clk, rst                 : clock, synchronous active-high reset
//   i_req/i_addr             : instruction request, level until i_gnt
//   i_gnt/i_rvalid/i_rdata   : instruction accept pulse and response
//   d_req/d_addr/d_we/d_wdata: data request (d_we=0 means read)
//   d_gnt/d_rvalid/d_rdata   : data accept pulse and response / write ack
//   mem_en/mem_we/mem_addr/mem_wdata/mem_rdata : memory side
// Build option ARB_ROUND_ROBIN_EN enables alternating priority on conflicts.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int RD_LAT = 1,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_gnt,
  output logic              i_rvalid,
  output logic [31:0]       i_rdata,
  input  logic              d_req,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [3:0]        d_we,
  input  logic [31:0]       d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [31:0]       d_rdata,
  output logic              mem_en,
  output logic [3:0]        mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  // Out-of-range latencies are clamped so the counter can never overflow.
  localparam int RD_LAT_C = (RD_LAT > RD_LAT_MAX) ? RD_LAT_MAX :
                            ((RD_LAT < 1) ? 1 : RD_LAT);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              owner_q, owner_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [3:0]        we_q, we_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       i_rdata_q, i_rdata_d;
  logic [31:0]       d_rdata_q, d_rdata_d;
  logic [31:0]       rd_word;
  logic              any_req;
  logic              win;

`ifdef ARB_ROUND_ROBIN_EN
  logic last_win_q, last_win_d;
`endif

  mem_arb_prio u_prio (
    .i_req    (i_req),
    .d_req    (d_req),
`ifdef ARB_ROUND_ROBIN_EN
    .last_win (last_win_q),
`endif
    .any_req  (any_req),
    .win      (win)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    owner_d   = owner_q;
    addr_d    = addr_q;
    we_d      = we_q;
    wdata_d   = wdata_q;
    i_rdata_d = i_rdata_q;
    d_rdata_d = d_rdata_q;
    rd_word   = 32'h0;
    i_gnt     = 1'b0;
    d_gnt     = 1'b0;
    mem_en    = 1'b0;
    mem_we    = 4'h0;
    mem_addr  = '0;
    mem_wdata = 32'h0;
`ifdef ARB_ROUND_ROBIN_EN
    last_win_d = last_win_q;
`endif

    case (state_q)
      IDLE: begin
        // Grant is suppressed while reset is held so no pulse escapes
        // for a request that the reset is about to discard.
        if (any_req && !rst) begin
          state_d = ISSUE;
          owner_d = win;
`ifdef ARB_ROUND_ROBIN_EN
          last_win_d = win;
`endif
          if (win == PORT_D) begin
            d_gnt   = 1'b1;
            addr_d  = d_addr;
            we_d    = d_we;
            wdata_d = d_wdata;
          end else begin
            i_gnt   = 1'b1;
            addr_d  = i_addr;
            we_d    = 4'h0;
            wdata_d = 32'h0;
          end
        end
      end
      ISSUE: begin
        mem_en    = 1'b1;
        mem_we    = we_q;
        mem_addr  = {addr_q[ADDR_W-1:2], 2'b00};
        mem_wdata = wdata_q;
        cnt_d     = CNT_W'(RD_LAT_C - 1);
        state_d   = WAIT;
      end
      WAIT: begin
        if (cnt_q == '0) begin
          // Writes return a zero word as their acknowledge.
          rd_word = (we_q != 4'h0) ? 32'h0 : mem_rdata;
          if (owner_q == PORT_D) begin
            d_rdata_d = rd_word;
          end else begin
            i_rdata_d = rd_word;
          end
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign i_rvalid = (state_q == RESP) && (owner_q == PORT_I);
  assign d_rvalid = (state_q == RESP) && (owner_q == PORT_D);
  assign i_rdata  = i_rdata_q;
  assign d_rdata  = d_rdata_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      owner_q   <= PORT_I;
      addr_q    <= '0;
      we_q      <= 4'h0;
      wdata_q   <= 32'h0;
      i_rdata_q <= 32'h0;
      d_rdata_q <= 32'h0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      owner_q   <= owner_d;
      addr_q    <= addr_d;
      we_q      <= we_d;
      wdata_q   <= wdata_d;
      i_rdata_q <= i_rdata_d;
      d_rdata_q <= d_rdata_d;
    end
  end

`ifdef ARB_ROUND_ROBIN_EN
  // Cleared to PORT_I so the first conflict after reset goes to the data port.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_win_q <= PORT_I;
    end else begin
      last_win_q <= last_win_d;
    end
  end
`endif

endmodule
